// File: rtl/oci_dct_packer_if.sv
// Handshake bundle between the trace encoder, the DCT packer and the trace FIFO.
// The code stream comes in on dct_in_*; closed packets go out on pkt_*.
interface oci_dct_packer_if;
  logic        dct_in_valid;
  logic [1:0]  dct_in_code;
  logic        dct_in_ready;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [29:0] pkt_data;
  logic [3:0]  pkt_count;

  modport master (
    output dct_in_valid,
    output dct_in_code,
    input  dct_in_ready,
    input  pkt_valid,
    output pkt_ready,
    input  pkt_data,
    input  pkt_count
  );

  modport slave (
    input  dct_in_valid,
    input  dct_in_code,
    output dct_in_ready,
    output pkt_valid,
    input  pkt_ready,
    output pkt_data,
    output pkt_count
  );
endinterface

// File: rtl/oci_dct_packer.sv
// Packs 2-bit direct-branch trace codes into 30-bit packets for the OCI trace FIFO.
// A packet closes when full, on flush, or when trace capture is switched off.
module oci_dct_packer #(
  parameter int MAX_CODES = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trace_enable,
  input  logic                    flush,
  oci_dct_packer_if.slave         dct,
  output logic [29:0]             dct_buffer,
  output logic [3:0]              dct_count,
  output logic [7:0]              drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT
  } state_t;

  localparam logic [3:0] MAX = 4'(MAX_CODES);

  state_t      state;
  logic        accept;
  logic        close;
  logic        refuse;
  logic [29:0] buf_nxt;
  logic [3:0]  cnt_nxt;

  assign dct.dct_in_ready = trace_enable && (state != EMIT);
  assign accept = dct.dct_in_valid && dct.dct_in_ready;
  assign refuse = dct.dct_in_valid && trace_enable
                  && !dct.dct_in_ready;

  always_comb begin
    buf_nxt = dct_buffer;
    cnt_nxt = dct_count;
    if (accept) begin
      buf_nxt = dct_buffer
              | (30'(dct.dct_in_code) << {dct_count, 1'b0});
      cnt_nxt = dct_count + 4'd1;
    end
  end

  // A same-cycle code is folded in before the packet closes.
  assign close = (accept && cnt_nxt == MAX)
              || (state == FILL && (flush || !trace_enable));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dct_buffer    <= '0;
      dct_count     <= '0;
      dct.pkt_valid <= 1'b0;
      dct.pkt_data  <= '0;
      dct.pkt_count <= '0;
    end else begin
      case (state)
        IDLE, FILL: begin
          dct_buffer <= buf_nxt;
          dct_count  <= cnt_nxt;
          if (close) begin
            state         <= EMIT;
            dct.pkt_valid <= 1'b1;
            dct.pkt_data  <= buf_nxt;
            dct.pkt_count <= cnt_nxt;
          end else if (cnt_nxt != 4'd0) begin
            state <= FILL;
          end
        end
        EMIT: begin
          if (dct.pkt_ready) begin
            state         <= IDLE;
            dct_buffer    <= '0;
            dct_count     <= '0;
            dct.pkt_valid <= 1'b0;
            dct.pkt_data  <= '0;
            dct.pkt_count <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (refuse && drop_count != 8'hff) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_oci_dct_packer.sv
// Scoreboard bench for oci_dct_packer: queue-based packing model plus a
// packet monitor, with a second MAX_CODES=1 instance.
module tb_oci_dct_packer;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic flush;
  logic [29:0] buf_o;
  logic [3:0]  cnt_o;
  logic [7:0]  drop_o;

  logic en1;
  logic flush1;
  logic [29:0] buf1;
  logic [3:0]  cnt1;
  logic [7:0]  drop1;

  always #5 clk = ~clk;

  oci_dct_packer_if u_if ();
  oci_dct_packer_if u_if1 ();

  oci_dct_packer #(.MAX_CODES(15)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .trace_enable (en),
    .flush        (flush),
    .dct          (u_if.slave),
    .dct_buffer   (buf_o),
    .dct_count    (cnt_o),
    .drop_count   (drop_o)
  );

  oci_dct_packer #(.MAX_CODES(1)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .trace_enable (en1),
    .flush        (flush1),
    .dct          (u_if1.slave),
    .dct_buffer   (buf1),
    .dct_count    (cnt1),
    .drop_count   (drop1)
  );

  typedef struct {
    logic [29:0] d;
    logic [3:0]  c;
  } pkt_t;

  int n_vec = 0;
  int n_fail = 0;
  int n_pkts = 0;
  logic [29:0] last_d;
  logic [3:0]  last_c;

  int   m_codes[$];
  bit   m_emit;
  int   m_drop;
  pkt_t sb[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [29:0] pack_codes();
    logic [29:0] v = '0;
    foreach (m_codes[k]) v = v + (30'(m_codes[k]) << (2 * k));
    return v;
  endfunction

  // Monitor: any held packet must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && u_if.pkt_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_pkt", {2'b0, u_if.pkt_data}, 32'h0);
      end else begin
        chk("pkt_data", {2'b0, u_if.pkt_data}, {2'b0, sb[0].d});
        chk("pkt_count", {28'b0, u_if.pkt_count}, {28'b0, sb[0].c});
        if (u_if.pkt_ready) begin
          last_d = sb[0].d;
          last_c = sb[0].c;
          void'(sb.pop_front());
          n_pkts++;
        end
      end
    end
  end

  // Check live outputs, then advance the model on the coming edge.
  task automatic step();
    bit rdy;
    int nb;
    @(negedge clk);
    if (reset) begin
      m_codes.delete();
      m_emit = 0;
      m_drop = 0;
      sb.delete();
    end else begin
      rdy = en && !m_emit;
      chk("in_ready", {31'b0, u_if.dct_in_ready}, {31'b0, rdy});
      chk("pkt_valid", {31'b0, u_if.pkt_valid}, {31'b0, m_emit});
      chk("dct_count", {28'b0, cnt_o}, m_codes.size());
      chk("dct_buffer", {2'b0, buf_o}, {2'b0, pack_codes()});
      chk("drop_count", {24'b0, drop_o}, m_drop);
      if (!u_if.pkt_valid)
        chk("pkt_idle_zero", {u_if.pkt_data, u_if.pkt_count}, 34'h0);
      if (u_if.dct_in_valid && en && !rdy && m_drop < 255)
        m_drop++;
      if (m_emit) begin
        if (u_if.pkt_ready) begin
          m_emit = 0;
          m_codes.delete();
        end
      end else begin
        nb = m_codes.size();
        if (u_if.dct_in_valid && rdy)
          m_codes.push_back(int'(u_if.dct_in_code));
        if (m_codes.size() == 15 || (nb > 0 && (flush || !en))) begin
          m_emit = 1;
          sb.push_back('{pack_codes(), 4'(m_codes.size())});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v, int code, bit fl);
    u_if.dct_in_valid = v;
    u_if.dct_in_code  = 2'(code);
    flush = fl;
    step();
  endtask

  initial begin
    int q1[$];
    bit exp_rdy;
    int c;
    reset = 1'b1;
    en = 1'b0;
    flush = 1'b0;
    u_if.dct_in_valid = 1'b0;
    u_if.dct_in_code  = 2'b00;
    u_if.pkt_ready    = 1'b1;
    en1 = 1'b0;
    flush1 = 1'b0;
    u_if1.dct_in_valid = 1'b0;
    u_if1.dct_in_code  = 2'b00;
    u_if1.pkt_ready    = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_pkt_valid", {31'b0, u_if.pkt_valid}, 32'h0);
    chk("rst_count", {28'b0, cnt_o}, 32'h0);
    chk("rst_drop", {24'b0, drop_o}, 32'h0);
    step();

    // Full packet, permanent ready.
    en = 1'b1;
    for (int k = 0; k < 15; k++) drive(1, (k % 2 == 0) ? 1 : 0, 0);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("full_data", {2'b0, last_d}, 32'h11111111);
    chk("full_count", {28'b0, last_c}, 32'd15);

    // Partial flush, then flush while idle.
    drive(1, 1, 0);
    drive(1, 1, 0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("part_data", {2'b0, last_d}, 32'h05);
    chk("part_count", {28'b0, last_c}, 32'd3);
    c = n_pkts;
    drive(0, 0, 1);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("idle_flush_pkts", n_pkts, c);

    // Flush with a code in the same cycle.
    drive(1, 1, 0);
    drive(1, 1, 0);
    drive(1, 1, 1);
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("fl_code_data", {2'b0, last_d}, 32'h15);
    chk("fl_code_count", {28'b0, last_c}, 32'd3);

    // Backpressure with codes still arriving.
    u_if.pkt_ready = 1'b0;
    for (int k = 0; k < 15; k++) drive(1, (k % 2 == 0) ? 1 : 0, 0);
    for (int k = 0; k < 10; k++) drive(1, 2, 0);
    chk("bp_drop", {24'b0, drop_o}, 32'd10);
    u_if.pkt_ready = 1'b1;
    drive(0, 0, 0);
    chk("bp_ready_after", {31'b0, u_if.dct_in_ready}, 32'd1);
    drive(0, 0, 0);

    // Trace enable dropping closes the partial packet.
    for (int k = 0; k < 4; k++) drive(1, 3 - k, 0);
    en = 1'b0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("en_count", {28'b0, last_c}, 32'd4);
    chk("en_data", {2'b0, last_d}, 32'h1b);
    for (int k = 0; k < 5; k++) drive(1, 1, 0);
    chk("en_drop", {24'b0, drop_o}, 32'd10);

    // Reset while a packet is held.
    en = 1'b1;
    u_if.pkt_ready = 1'b0;
    drive(1, 1, 0);
    drive(1, 2, 1);
    drive(0, 0, 0);
    chk("hold_valid", {31'b0, u_if.pkt_valid}, 32'd1);
    reset = 1'b1;
    drive(0, 0, 0);
    reset = 1'b0;
    chk("rst_emit_valid", {31'b0, u_if.pkt_valid}, 32'h0);
    chk("rst_emit_count", {28'b0, cnt_o}, 32'h0);
    chk("rst_emit_drop", {24'b0, drop_o}, 32'h0);
    drive(0, 0, 0);

    // Drop counter saturation.
    for (int k = 0; k < 15; k++) drive(1, k % 4, 0);
    for (int k = 0; k < 300; k++) drive(1, 1, 0);
    chk("drop_sat", {24'b0, drop_o}, 32'd255);
    u_if.pkt_ready = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      en = ($urandom % 16) != 0;
      u_if.pkt_ready = ($urandom % 10) < 7;
      reset = ($urandom % 600) == 0;
      drive(($urandom % 4) != 0, int'($urandom % 4),
            ($urandom % 12) == 0);
    end
    reset = 1'b0;
    en = 1'b1;
    u_if.pkt_ready = 1'b1;
    for (int k = 0; k < 4; k++) drive(0, 0, 0);
    chk("sb_drained", sb.size(), 32'd0);

    // MAX_CODES=1: each accepted code is its own packet.
    en1 = 1'b1;
    u_if1.dct_in_valid = 1'b1;
    exp_rdy = 1;
    for (int k = 0; k < 16; k++) begin
      c = int'($urandom % 4);
      u_if1.dct_in_code = 2'(c);
      @(negedge clk);
      chk("m1_ready", {31'b0, u_if1.dct_in_ready}, {31'b0, exp_rdy});
      chk("m1_valid", {31'b0, u_if1.pkt_valid}, {31'b0, !exp_rdy});
      if (exp_rdy) begin
        q1.push_back(c);
      end else begin
        chk("m1_data", {2'b0, u_if1.pkt_data}, q1.pop_front());
        chk("m1_count", {28'b0, u_if1.pkt_count}, 32'd1);
      end
      exp_rdy = !exp_rdy;
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/oci_dct_packer.md
# oci_dct_packer

Sequences direct-branch trace codes from the Nios II OCI trace front end into the 30-bit DCT packing buffer. The block owns `dct_buffer`/`dct_count`, decides when a packet is closed, and hands closed packets to the trace frame FIFO over a valid/ready handshake. It sits between the instruction-trace encoder and the OCI trace FIFO. `dct_buffer`/`dct_count` are also exported so the OCI test bench monitor can observe packing live.

## Interface
- MAX_CODES, 15, codes per full packet; legal range 1..15. Buffer width is fixed at 30 bits.
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- trace_enable  in  1  trace capture enabled
- dct_in_valid  in  1  a 2-bit direct-branch code is presented
- dct_in_code  in  2  code: 00 not-taken, 01 taken, 10/11 reserved but packed as-is
- dct_in_ready  out  1  code accepted this cycle when valid && ready
- flush  in  1  single-cycle pulse (indirect branch/exception); closes a partial packet
- pkt_valid  out  1  closed packet available
- pkt_ready  in  1  FIFO accepts packet
- pkt_data  out  30  packed codes
- pkt_count  out  4  number of valid codes in pkt_data
- dct_buffer  out  30  live packing buffer
- dct_count  out  4  live code count
- drop_count  out  8  saturating count of codes refused while trace_enable=1

## Operation
- States: IDLE (count 0), FILL (0 < count < MAX_CODES), EMIT (packet held for FIFO).
- dct_in_ready = trace_enable && state != EMIT.
- Packing: the k-th accepted code (k from 0) is written to dct_buffer[2k+1:2k]. Bits above 2*dct_count are always zero.
- IDLE/FILL on accept: the code is written and the count is incremented. If the new count == MAX_CODES, go to EMIT.
- FILL on flush: go to EMIT. If a code is accepted in the same cycle, it is included first.
- IDLE on flush: ignored. Empty packets are never emitted.
- FILL with trace_enable falling to 0: treated as flush, go to EMIT.
- EMIT: pkt_valid=1, pkt_data=dct_buffer, pkt_count=dct_count. Both are held stable until pkt_ready.
- On the EMIT handshake (pkt_valid && pkt_ready), the next cycle is IDLE with dct_buffer=0 and dct_count=0.
- flush in EMIT is ignored and not queued.
- drop_count increments when dct_in_valid && trace_enable && !dct_in_ready. It saturates at 255 and clears only on reset.
- Codes presented while trace_enable=0 are not accepted and not counted.
- pkt_data/pkt_count outputs are 0 outside EMIT.

## Timing
- Reset values: state IDLE, dct_buffer 0, dct_count 0, pkt_valid 0, pkt_data 0, pkt_count 0, drop_count 0. dct_in_ready follows trace_enable combinationally.
- All outputs except dct_in_ready are registered.
- Latency: pkt_valid rises 1 cycle after the accept that fills the buffer, or 1 cycle after the flush edge.
- Back-to-back: after the handshake in cycle N, dct_in_ready=1 in cycle N+1. Minimum packet period for MAX_CODES=15 is 15 + 1 (EMIT) cycles.
- Reset mid-operation: a partial buffer or held packet is discarded with no emit, and all state returns to reset values on the next edge.
- pkt_ready may be high permanently. The handshake then completes in the first EMIT cycle.

## Test plan
- Full packet: enable=1, codes 01,00 alternating ×15, pkt_ready=1 → one packet, pkt_count=15, pkt_data=30'h11111111, pkt_valid high for 1 cycle, then dct_count=0.
- Partial flush: 3 codes 01,01,00 then flush → pkt_count=3, pkt_data=30'h05. Flush again while IDLE → no packet.
- Flush with simultaneous code: 2 codes buffered, third code (01) and flush in the same cycle → pkt_count=3, pkt_data=30'h15 (pattern follows the first two codes).
- Backpressure: fill 15 codes, pkt_ready=0 for 10 cycles while valid codes are presented → pkt_data stable, dct_in_ready=0, drop_count=10. Raise pkt_ready → handshake, then ready=1 next cycle.
- Enable drop: 4 codes buffered, trace_enable→0 → packet pkt_count=4 emitted. Later codes with enable=0 are ignored and drop_count is unchanged.
- Reset in EMIT: hold packet, assert reset 1 cycle → pkt_valid=0, dct_count=0, drop_count=0, state IDLE. MAX_CODES=1 build: each code emits its own packet.
